// File: rtl/cpu8bit_pkg.sv
// Shared definitions for the 8-bit CPU datapath: the one-hot bus-select destination
// codes, the datapath width and the write-back FSM state type.
package cpu8bit_pkg;

    localparam int DATA_W = 8;

    localparam logic [4:0] DEST_A   = 5'b10000;
    localparam logic [4:0] DEST_B   = 5'b01000;
    localparam logic [4:0] DEST_C   = 5'b00100;
    localparam logic [4:0] DEST_D   = 5'b00010;
    localparam logic [4:0] DEST_BUF = 5'b00001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FAULT = 2'd2
    } wb_state_t;

endpackage

// File: rtl/regbank_onehot_chk.sv
// Combinational legality check for a 5-bit one-hot bus-select code. The flag is set
// only when exactly one bit is set, so the all-zero code is also rejected.
module regbank_onehot_chk (
    input  logic [4:0] code,
    output logic       legal
);

    // Clearing the lowest set bit leaves zero only for codes with a single bit set.
    assign legal = (code != 5'd0) && ((code & (code - 5'd1)) == 5'd0);

endmodule

// File: rtl/regbank_wb.sv
// Register write-back unit: accepts a result byte with a one-hot destination, holds it
// in a one-entry pending slot and commits it to A/B/C/D/Buffer0 on the next edge.
// A malformed destination code drops the request and parks the unit in a sticky fault.
// Optional macro REGBANK_BYPASS_EN forwards the pending slot onto the register outputs.
module regbank_wb
    import cpu8bit_pkg::*;
#(
    parameter int DATA_W = cpu8bit_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [4:0]        ctl_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              clr_err_i,
    output logic [DATA_W-1:0] A_o,
    output logic [DATA_W-1:0] B_o,
    output logic [DATA_W-1:0] C_o,
    output logic [DATA_W-1:0] D_o,
    output logic [DATA_W-1:0] Buffer0_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    wb_state_t         state;
    wb_state_t         state_next;
    logic              legal;
    logic              accept;
    logic              commit;
    logic [DATA_W-1:0] pend_data;
    logic [4:0]        pend_dest;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] reg_c;
    logic [DATA_W-1:0] reg_d;
    logic [DATA_W-1:0] reg_buf;
    logic [CNT_W-1:0]  count;

    regbank_onehot_chk u_chk (
        .code  (ctl_i),
        .legal (legal)
    );

    assign accept = valid_i && ready_o;
    assign commit = (state == PEND);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = legal ? PEND : FAULT;
                end
            end
            PEND: begin
                if (accept) begin
                    state_next = legal ? PEND : FAULT;
                end else begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                if (clr_err_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ready depends on the state register only; the fault flag is the FAULT state itself.
    always_comb begin
        ready_o = (state != FAULT);
        err_o   = (state == FAULT);
    end

    // The slot needs no reset: its contents are only used while the FSM is in PEND.
    always_ff @(posedge clk_i) begin
        if (accept && legal) begin
            pend_data <= data_i;
            pend_dest <= ctl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_a   <= '0;
            reg_b   <= '0;
            reg_c   <= '0;
            reg_d   <= '0;
            reg_buf <= '0;
        end else if (commit) begin
            case (pend_dest)
                DEST_A:   reg_a   <= pend_data;
                DEST_B:   reg_b   <= pend_data;
                DEST_C:   reg_c   <= pend_data;
                DEST_D:   reg_d   <= pend_data;
                DEST_BUF: reg_buf <= pend_data;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (commit) begin
            count <= count + 1'b1;
        end
    end

    assign wr_count_o = count;

`ifdef REGBANK_BYPASS_EN
    always_comb begin
        A_o       = (commit && pend_dest == DEST_A)   ? pend_data : reg_a;
        B_o       = (commit && pend_dest == DEST_B)   ? pend_data : reg_b;
        C_o       = (commit && pend_dest == DEST_C)   ? pend_data : reg_c;
        D_o       = (commit && pend_dest == DEST_D)   ? pend_data : reg_d;
        Buffer0_o = (commit && pend_dest == DEST_BUF) ? pend_data : reg_buf;
    end
`else
    assign A_o       = reg_a;
    assign B_o       = reg_b;
    assign C_o       = reg_c;
    assign D_o       = reg_d;
    assign Buffer0_o = reg_buf;
`endif

endmodule
